branch_resolve_predict_unit: RTL
================================

# branch_resolve_predict_unit

Parametrised branch unit for the next-generation RISC-V core. It resolves all six RV32I conditional branches (beq, bne, blt, bge, bltu, bgeu) by comparing register operands directly, so it no longer depends on ALU zero/sign flags. It holds a direct-mapped branch history table (BHT) of 2-bit saturating counters that supplies a fetch-stage prediction. It also produces a registered mispredict/redirect pair for the fetch unit. It sits between decode/execute (resolve side) and fetch (predict side).

## Interface
- XLEN, 32, operand and PC width
- BHT_IDX_W, 4, log2 of BHT entries (default 16 entries)
- CNT_W, 32, width of the statistics counters (used only with BPU_STATS_EN)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pred_pc  in  XLEN  fetch-stage PC to predict
- pred_taken  out  1  combinational prediction for pred_pc
- res_valid  in  1  a conditional branch resolves this cycle
- res_funct3  in  3  branch funct3
- res_pc  in  XLEN  PC of resolving branch
- res_rs1, res_rs2  in  XLEN  operands
- res_target  in  XLEN  computed taken target
- res_pred_taken  in  1  prediction used when this branch was fetched
- branch_out  out  1  combinational actual outcome
- illegal_funct3  out  1  combinational; res_valid with funct3 010 or 011
- mispredict_q  out  1  registered mispredict pulse
- redirect_pc_q  out  XLEN  registered correct next PC
- stat_branches, stat_mispredicts  out  CNT_W  performance counters

## Operation
- Conditions: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge. All comparisons are full XLEN.
- A branch is legal when res_valid=1 and funct3 is not in {010,011}.
- branch_out = legal & condition. It is 0 when res_valid=0 or funct3 is illegal.
- BHT index = PC[BHT_IDX_W+1:2]. Bits [1:0] are ignored.
- pred_taken is bit 1 of the entry at pred_pc's index.
- Update on a legal branch: the entry at res_pc's index increments if taken and decrements if not.
  - Saturates at 3 and at 0.
  - States: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- No BHT update on an illegal or invalid cycle.
- Mispredict = legal & (branch_out != res_pred_taken).
- Redirect PC = branch_out ? res_target : res_pc + 4. The addition is modulo 2^XLEN, so 0xFFFFFFFC wraps to 0.
- Same-cycle read/write of one index: pred_taken returns the pre-update value. There is no bypass.
- Reset values:
  - every BHT entry = 1 (weak-NT)
  - mispredict_q = 0
  - redirect_pc_q = 0
  - stat counters = 0
- Reset has priority over a simultaneous res_valid. The update is discarded.

## Timing
- pred_taken, branch_out and illegal_funct3 are zero-latency combinational outputs.
- mispredict_q and redirect_pc_q are captured on the edge ending the resolve cycle and are valid the following cycle.
  - mispredict_q is a one-cycle pulse; it is 0 in every cycle not preceded by a mispredicting legal branch.
  - redirect_pc_q holds its last value when not updated.
- A BHT update is visible on pred_taken from the cycle after the resolve edge.
- Back-to-back resolves every cycle are supported with no stalls.

## Configuration
- BPU_STATS_EN defined:
  - stat_branches increments once per legal branch.
  - stat_mispredicts increments once per mispredict.
  - Both wrap at 2^CNT_W and clear on reset.
- BPU_STATS_EN undefined: no counter registers; both outputs are tied to 0.

## Test plan
- Reset, then pred_pc=0x40 -> pred_taken=0. Hold reset with res_valid=1 taken -> entry unchanged, mispredict_q=0.
- funct3=100, rs1=0xFFFFFFFF, rs2=1 -> branch_out=1. funct3=110, same operands -> branch_out=0. funct3=101 and 111 give the complements.
- Resolve beq taken at res_pc=0x40 three times -> entry goes 1→2→3→3. pred_taken becomes 1 the cycle after the first update. Two not-taken resolves -> 3→2→1, pred_taken=0.
- bne not-taken, res_pred_taken=1, res_pc=0x100 -> next cycle mispredict_q=1, redirect_pc_q=0x104, then mispredict_q=0. Taken, res_pred_taken=0, target 0x200 -> redirect_pc_q=0x200.
- funct3=010, res_valid=1 -> illegal_funct3=1, branch_out=0, no BHT change, no mispredict. res_pc=0xFFFFFFFC not-taken mispredicted -> redirect_pc_q=0.
- With BPU_STATS_EN and CNT_W=4: 17 legal branches -> stat_branches=1. 3 of them mispredicted -> stat_mispredicts=3. Without the macro both read 0.

Source files
------------

// File: rtl/branch_resolve_predict_unit_if.sv
// Resolve/predict bus between decode-execute, fetch and the branch unit.
interface branch_resolve_predict_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic [XLEN-1:0]  pred_pc;
  logic             pred_taken;
  logic             res_valid;
  logic [2:0]       res_funct3;
  logic [XLEN-1:0]  res_pc;
  logic [XLEN-1:0]  res_rs1;
  logic [XLEN-1:0]  res_rs2;
  logic [XLEN-1:0]  res_target;
  logic             res_pred_taken;
  logic             branch_out;
  logic             illegal_funct3;
  logic             mispredict_q;
  logic [XLEN-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  modport master (
    output pred_pc, res_valid, res_funct3, res_pc, res_rs1, res_rs2,
           res_target, res_pred_taken,
    input  pred_taken, branch_out, illegal_funct3, mispredict_q,
           redirect_pc_q, stat_branches, stat_mispredicts
  );

  modport slave (
    input  pred_pc, res_valid, res_funct3, res_pc, res_rs1, res_rs2,
           res_target, res_pred_taken,
    output pred_taken, branch_out, illegal_funct3, mispredict_q,
           redirect_pc_q, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolve_predict_unit.sv
// RV32I branch resolver with a 2-bit-counter BHT predictor and registered redirect.
// Optional performance counters are enabled by defining BPU_STATS_EN.
module branch_resolve_predict_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_IDX_W = 4,
  parameter int unsigned CNT_W     = 32
) (
  input logic                   clk,
  input logic                   reset,
  branch_resolve_predict_unit_if.slave bus
);
  localparam int unsigned BHT_N = 1 << BHT_IDX_W;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } bht_state_e;

  bht_state_e            bht [BHT_N];
  bht_state_e            upd_state;
  logic [BHT_IDX_W-1:0]  pred_idx;
  logic [BHT_IDX_W-1:0]  res_idx;
  logic                  illegal;
  logic                  legal;
  logic                  cond;
  logic                  taken;
  logic                  mispredict;
  logic [XLEN-1:0]       next_pc;
  logic                  unused_pred_bits;

  assign pred_idx         = bus.pred_pc[BHT_IDX_W+1:2];
  assign res_idx          = bus.res_pc[BHT_IDX_W+1:2];
  assign unused_pred_bits = ^{bus.pred_pc[XLEN-1:BHT_IDX_W+2], bus.pred_pc[1:0]};

  // Read of the registered table: a same-cycle update is not bypassed.
  assign bus.pred_taken     = bht[pred_idx] inside {WEAK_T, STRONG_T};
  assign bus.branch_out     = taken;
  assign bus.illegal_funct3 = bus.res_valid & illegal;

  always_comb begin
    cond    = 1'b0;
    illegal = (bus.res_funct3[2:1] == 2'b01);
    case (bus.res_funct3)
      3'b000:  cond = (bus.res_rs1 == bus.res_rs2);
      3'b001:  cond = (bus.res_rs1 != bus.res_rs2);
      3'b100:  cond = ($signed(bus.res_rs1) <  $signed(bus.res_rs2));
      3'b101:  cond = ($signed(bus.res_rs1) >= $signed(bus.res_rs2));
      3'b110:  cond = (bus.res_rs1 <  bus.res_rs2);
      3'b111:  cond = (bus.res_rs1 >= bus.res_rs2);
      default: cond = 1'b0;
    endcase
    legal      = bus.res_valid & ~illegal;
    taken      = legal & cond;
    mispredict = legal & (taken != bus.res_pred_taken);
    next_pc    = taken ? bus.res_target : bus.res_pc + XLEN'(4);

    upd_state = bht[res_idx];
    case (bht[res_idx])
      STRONG_NT: upd_state = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   upd_state = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    upd_state = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  upd_state = taken ? STRONG_T : WEAK_T;
      default:   upd_state = WEAK_NT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_N; i++) begin
        bht[BHT_IDX_W'(i)] <= WEAK_NT;
      end
      bus.mispredict_q  <= 1'b0;
      bus.redirect_pc_q <= '0;
    end else begin
      bus.mispredict_q <= mispredict;
      if (legal) begin
        bht[res_idx]      <= upd_state;
        bus.redirect_pc_q <= next_pc;
      end
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.stat_branches    <= '0;
      bus.stat_mispredicts <= '0;
    end else begin
      if (legal) begin
        bus.stat_branches <= bus.stat_branches + CNT_W'(1);
      end
      if (mispredict) begin
        bus.stat_mispredicts <= bus.stat_mispredicts + CNT_W'(1);
      end
    end
  end
`else
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif
endmodule
